lzx_cmp_seq: RTL and testbench
==============================

Name: lzx_cmp_seq

Overview:
- Multi-cycle magnitude-compare sequencer for operands wider than one 4-bit compare slice.
- Captures two NIBBLES*4-bit operands on a start handshake.
- Walks them through a single 4-bit compare slice, one nibble per cycle, most significant nibble first, cascading the partial result.
- Reports A>B / A==B / A<B with a done pulse. This lets wide compares reuse one slice instead of chaining NIBBLES slices.

Parameters:
- NIBBLES, 4, operand width in nibbles (operand width W = 4*NIBBLES). Legal range >= 1.

Ports:
- clk    in   1   clock, rising edge.
- rst_n  in   1   asynchronous active-low reset.
- start  in   1   request; sampled only in IDLE.
- A      in   W   operand A; captured when start is accepted.
- B      in   W   operand B; captured when start is accepted.
- IA_g   in   1   cascade-in "greater" from the less-significant stage; captured with operands.
- IA_e   in   1   cascade-in "equal"; captured with operands.
- IA_l   in   1   cascade-in "less"; captured with operands.
- busy   out  1   high while in RUN.
- done   out  1   one-cycle pulse; the result is valid from this cycle onward.
- QA_g   out  1   result A>B (registered, held).
- QA_e   out  1   result A==B (registered, held).
- QA_l   out  1   result A<B (registered, held).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy, done, QA_g, QA_e, QA_l = 0.
  - Nibble index and operand/cascade registers cleared.
  - Takes effect immediately, including mid-RUN; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - Capture A, B, IA_g/e/l.
  - Clear QA_* to 0.
  - idx <= NIBBLES-1; go to RUN.
- IDLE, start=0: stay.
- RUN (busy=1), each cycle, compare nibble idx of A vs B with the slice (unsigned 4-bit):
  - Nibble A > B: QA_g<=1, go to DONE.
  - Nibble A < B: QA_l<=1, go to DONE.
  - Nibbles equal, idx>0: idx <= idx-1, stay in RUN.
  - Nibbles equal, idx==0: apply cascade with priority IA_g > IA_l > IA_e.
    - IA_g: QA_g=1. IA_l: QA_l=1. IA_e: QA_e=1.
    - None asserted: all QA_* stay 0 (undetermined). Go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. start in the DONE cycle is ignored.
- start while busy or in DONE has no effect. Operand and cascade input changes after capture have no effect.
- Result flags are one-hot or all-zero at all times. They hold their value until the next accepted start or reset.
- Latency, start-sample edge to done:
  - k+1 cycles, where k = nibbles examined (1..NIBBLES).
  - Fixed NIBBLES+1 when early exit is disabled (see Optional Feature).
- The cascade inputs only matter when all nibbles are equal. An unequal nibble always overrides the cascade.
- idx width = max(1, clog2(NIBBLES)). NIBBLES=1 gives a single RUN cycle.

Optional Feature:
- Macro: LZX_CMP_SEQ_EARLY_EXIT_EN.
- Defined: RUN exits to DONE at the first unequal nibble, as described above.
- Undefined (constant-time mode):
  - RUN always spends exactly NIBBLES cycles.
  - The first unequal nibble's decision is latched in a sticky internal flag; later nibbles are compared but do not alter it.
  - Result flags are written on the idx==0 cycle.
  - Latency is always NIBBLES+1; results are identical to the defined case.

Decomposition:
- Shared package lzx_cmp_pkg holds:
  - State enum (IDLE/RUN/DONE).
  - 2-bit compare-result encoding (GT/EQ/LT/NONE).
  - NIBBLE_W=4 constant.
- One natural sub-module: lzx_cmp_nibble, a combinational 4-bit unsigned compare returning gt/eq/lt. It is instantiated once and shared across all cycles.

Test Plan (NIBBLES=4):
1. A=16'h1234, B=16'h1234, IA_e=1, start for one cycle -> busy for 4 cycles; done 5 cycles after start; QA_e=1, QA_g=QA_l=0, held afterward.
2. A=16'h9000, B=16'h1FFF -> QA_g=1. Done 2 cycles after start with LZX_CMP_SEQ_EARLY_EXIT_EN; 5 cycles without.
3. A=16'h00F0, B=16'h00F1, IA_g=1 -> QA_l=1 after 4 RUN cycles; the cascade is ignored.
4. Equal operands, IA_g=1 and IA_l=1 -> QA_g=1. Equal operands, all IA_*=0 -> done pulses with QA_g=QA_e=QA_l=0.
5. start held high and A/B changed during RUN and in the DONE cycle -> only the first request is processed; the result matches the captured operands; the next start is accepted in IDLE only.
6. rst_n driven low on the 2nd RUN cycle -> busy, done and QA_* read 0 immediately; state is IDLE; no done pulse after rst_n releases; a new start then completes normally.

Source files
------------

// File: rtl/lzx_cmp_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states, result encoding, slice width.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package lzx_cmp_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // NONE means "undetermined": every nibble equal and no cascade input asserted.
    typedef enum logic [1:0] {
        CMP_NONE = 2'b00,
        CMP_GT   = 2'b01,
        CMP_EQ   = 2'b10,
        CMP_LT   = 2'b11
    } cmp_res_t;

    // Cascade inputs resolve with priority greater > less > equal.
    function automatic cmp_res_t cascade_res(input logic g, input logic e, input logic l);
        cmp_res_t r;
        if (g)      r = CMP_GT;
        else if (l) r = CMP_LT;
        else if (e) r = CMP_EQ;
        else        r = CMP_NONE;
        return r;
    endfunction

endpackage

// File: rtl/lzx_cmp_seq_if.sv
// Request/result bundle between a requester (master) and the comparator (slave).
// Latency: n/a (wires only).
// Backpressure: start is only honoured while the comparator is idle; busy marks the refusal window.
// Signals: start, A, B, IA_g/e/l (requester -> comparator); busy, done, QA_g/e/l (comparator -> requester).
interface lzx_cmp_seq_if #(
    parameter int NIBBLES = 4
);
    localparam int W = lzx_cmp_pkg::NIBBLE_W * NIBBLES;

    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         IA_g;
    logic         IA_e;
    logic         IA_l;
    logic         busy;
    logic         done;
    logic         QA_g;
    logic         QA_e;
    logic         QA_l;

    modport master (
        output start, A, B, IA_g, IA_e, IA_l,
        input  busy, done, QA_g, QA_e, QA_l
    );

    modport slave (
        input  start, A, B, IA_g, IA_e, IA_l,
        output busy, done, QA_g, QA_e, QA_l
    );

endinterface

// File: rtl/lzx_cmp_nibble.sv
// Single 4-bit unsigned magnitude compare slice, shared by every step of the sequencer.
// Latency: combinational.
// Backpressure: none.
// Ports: a_i, b_i (nibbles in); gt_o, eq_o, lt_o (exactly one high).
module lzx_cmp_nibble
    import lzx_cmp_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    output logic                gt_o,
    output logic                eq_o,
    output logic                lt_o
);

    assign gt_o = (a_i >  b_i);
    assign eq_o = (a_i == b_i);
    assign lt_o = (a_i <  b_i);

endmodule

// File: rtl/lzx_cmp_seq.sv
// Wide A-vs-B magnitude compare walked MS nibble first through one shared 4-bit slice.
// Latency: done appears k+1 cycles after the start cycle (k = nibbles examined), NIBBLES+1 in constant-time mode.
// Backpressure: start is ignored while busy and during the done cycle; results hold until the next accepted start.
// Ports: clk, rst_n (async active-low); bus (slave modport: start/A/B/IA_* in, busy/done/QA_* out).
// Build option: define LZX_CMP_SEQ_EARLY_EXIT_EN to leave RUN at the first unequal nibble;
// without it RUN always lasts NIBBLES cycles and the first difference is held in a sticky flag.
module lzx_cmp_seq
    import lzx_cmp_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    lzx_cmp_seq_if.slave   bus
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic               cas_g_q;
    logic               cas_e_q;
    logic               cas_l_q;
    logic               busy_q;
    logic               done_q;
    logic               qa_g_q;
    logic               qa_e_q;
    logic               qa_l_q;
`ifndef LZX_CMP_SEQ_EARLY_EXIT_EN
    cmp_res_t           sticky_q;   // EQ until the first unequal nibble, then frozen
`endif

    logic [NIBBLE_W-1:0] nib_a;
    logic [NIBBLE_W-1:0] nib_b;
    logic                s_gt;
    logic                s_eq;
    logic                s_lt;
    logic                last_d;
    cmp_res_t            res_d;

    assign nib_a  = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
    assign nib_b  = b_q[idx_q*NIBBLE_W +: NIBBLE_W];
    assign last_d = (idx_q == '0);

    lzx_cmp_nibble u_slice (
        .a_i  (nib_a),
        .b_i  (nib_b),
        .gt_o (s_gt),
        .eq_o (s_eq),
        .lt_o (s_lt)
    );

    // Decision for the current RUN cycle: an unequal nibble beats the cascade;
    // the cascade only decides when every nibble compared equal.
    always_comb begin
        res_d = CMP_NONE;
`ifndef LZX_CMP_SEQ_EARLY_EXIT_EN
        if (sticky_q != CMP_EQ)
            res_d = sticky_q;
        else
`endif
        if (s_gt)
            res_d = CMP_GT;
        else if (s_lt)
            res_d = CMP_LT;
        else
            res_d = cascade_res(cas_g_q, cas_e_q, cas_l_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cas_g_q  <= 1'b0;
            cas_e_q  <= 1'b0;
            cas_l_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            qa_g_q   <= 1'b0;
            qa_e_q   <= 1'b0;
            qa_l_q   <= 1'b0;
`ifndef LZX_CMP_SEQ_EARLY_EXIT_EN
            sticky_q <= CMP_NONE;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_q      <= bus.A;
                        b_q      <= bus.B;
                        cas_g_q  <= bus.IA_g;
                        cas_e_q  <= bus.IA_e;
                        cas_l_q  <= bus.IA_l;
                        qa_g_q   <= 1'b0;
                        qa_e_q   <= 1'b0;
                        qa_l_q   <= 1'b0;
                        idx_q    <= IDX_LAST;
                        busy_q   <= 1'b1;
`ifndef LZX_CMP_SEQ_EARLY_EXIT_EN
                        sticky_q <= CMP_EQ;
`endif
                        state_q  <= ST_RUN;
                    end
                end

                ST_RUN: begin
`ifdef LZX_CMP_SEQ_EARLY_EXIT_EN
                    if (!s_eq || last_d) begin
`else
                    if (last_d) begin
`endif
                        qa_g_q  <= (res_d == CMP_GT);
                        qa_e_q  <= (res_d == CMP_EQ);
                        qa_l_q  <= (res_d == CMP_LT);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        idx_q <= idx_q - IDX_W'(1);
`ifndef LZX_CMP_SEQ_EARLY_EXIT_EN
                        // Only the first unequal nibble is remembered.
                        if (sticky_q == CMP_EQ && !s_eq)
                            sticky_q <= res_d;
`endif
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.QA_g = qa_g_q;
    assign bus.QA_e = qa_e_q;
    assign bus.QA_l = qa_l_q;

endmodule

// File: tb/tb_lzx_cmp_seq.sv
// Self-checking bench for lzx_cmp_seq with NIBBLES=4: directed cases plus randomized traffic
// against a transaction-level model (full-width compare, latency from first differing nibble).
// Outputs are compared on every falling clock edge.
module tb_lzx_cmp_seq;
    import lzx_cmp_pkg::*;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;
`ifdef LZX_CMP_SEQ_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lzx_cmp_seq_if #(.NIBBLES(NIB)) bus ();

    lzx_cmp_seq #(.NIBBLES(NIB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Expected flags {g,e,l}: the full-width relation, or the cascade when A==B.
    function automatic logic [2:0] ref_flags(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [2:0] cas);
        if (a > b)       return 3'b100;
        if (a < b)       return 3'b001;
        if (cas[2])      return 3'b100;
        if (cas[0])      return 3'b001;
        if (cas[1])      return 3'b010;
        return 3'b000;
    endfunction

    // Number of RUN cycles for this operand pair.
    function automatic int ref_k(input logic [W-1:0] a, input logic [W-1:0] b);
        int k_first = NIB;
        for (int i = 0; i < NIB; i++)
            if (a[i*4 +: 4] != b[i*4 +: 4]) k_first = NIB - i;
        return EARLY ? k_first : NIB;
    endfunction

    // Transaction model: remaining RUN cycles, done flag, and held result.
    int         m_left  = 0;
    bit         m_done  = 1'b0;
    logic [2:0] m_flags = 3'b000;
    logic [2:0] m_pend  = 3'b000;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left  = 0;
            m_done  = 1'b0;
            m_flags = 3'b000;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done  = 1'b1;
                m_flags = m_pend;
            end
        end else if (bus.start) begin
            m_flags = 3'b000;
            m_left  = ref_k(bus.A, bus.B);
            m_pend  = ref_flags(bus.A, bus.B, {bus.IA_g, bus.IA_e, bus.IA_l});
        end
    end

    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en)
            check("cycle_outputs",
                  {27'd0, bus.busy, bus.done, bus.QA_g, bus.QA_e, bus.QA_l},
                  {27'd0, (m_left > 0), m_done, m_flags});
    end

    function automatic logic [2:0] dut_flags();
        return {bus.QA_g, bus.QA_e, bus.QA_l};
    endfunction

    // Issue one request; operands/cascade are scrambled every cycle after capture.
    // hold keeps start high until done. cyc = falling edges from start cycle to the done cycle.
    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] cas,
                           input bit hold, output int cyc);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A = a;
        bus.B = b;
        {bus.IA_g, bus.IA_e, bus.IA_l} = cas;
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (!hold) bus.start = 1'b0;
            bus.A = W'($urandom);
            bus.B = W'($urandom);
            {bus.IA_g, bus.IA_e, bus.IA_l} = 3'($urandom);
            if (bus.done) break;
        end
        bus.start = 1'b0;
        if (!bus.done) check("done_timeout", 32'(cyc), 32'd0);
    endtask

    int         cyc;
    logic [W-1:0] ra, rb;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        {bus.IA_g, bus.IA_e, bus.IA_l} = 3'b000;
        repeat (3) @(negedge clk);
        check("reset_outputs", {27'd0, bus.busy, bus.done, dut_flags()}, 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Pin the model itself.
        check("model_gt", ref_flags(16'h9000, 16'h1FFF, 3'b000), 3'b100);
        check("model_k",  ref_k(16'h9000, 16'h1FFF), EARLY ? 32'd1 : 32'd4);

        // 1: equal, cascade equal.
        run_txn(16'h1234, 16'h1234, 3'b010, 1'b0, cyc);
        check("t1_latency", cyc, 5);
        check("t1_flags", dut_flags(), 3'b010);
        repeat (3) @(negedge clk);
        check("t1_held", dut_flags(), 3'b010);

        // 2: MS nibble decides.
        run_txn(16'h9000, 16'h1FFF, 3'b000, 1'b0, cyc);
        check("t2_latency", cyc, EARLY ? 2 : 5);
        check("t2_flags", dut_flags(), 3'b100);

        // 3: LS nibble decides, cascade ignored.
        run_txn(16'h00F0, 16'h00F1, 3'b100, 1'b0, cyc);
        check("t3_latency", cyc, 5);
        check("t3_flags", dut_flags(), 3'b001);

        // 4: cascade priority and undetermined result.
        run_txn(16'hABCD, 16'hABCD, 3'b101, 1'b0, cyc);
        check("t4a_flags", dut_flags(), 3'b100);
        run_txn(16'hABCD, 16'hABCD, 3'b000, 1'b0, cyc);
        check("t4b_latency", cyc, 5);
        check("t4b_flags", dut_flags(), 3'b000);

        // 5: start held, operands churn after capture.
        run_txn(16'h5000, 16'h4000, 3'b001, 1'b1, cyc);
        check("t5_latency", cyc, EARLY ? 2 : 5);
        check("t5_flags", dut_flags(), 3'b100);
        repeat (3) @(negedge clk);

        // 6: reset on the second RUN cycle.
        @(negedge clk);
        bus.start = 1'b1;
        bus.A = 16'h1235;
        bus.B = 16'h1234;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_outputs", {27'd0, bus.busy, bus.done, dut_flags()}, 32'd0);
        check("t6_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("t6_no_done", {31'd0, bus.done}, 32'd0);
        end
        run_txn(16'h1235, 16'h1234, 3'b000, 1'b0, cyc);
        check("t6_after_latency", cyc, 5);
        check("t6_after_flags", dut_flags(), 3'b100);

        // Random traffic: mostly-equal operands so every nibble position gets to decide.
        for (int t = 0; t < 300; t++) begin
            ra = W'($urandom);
            rb = ra;
            for (int n = 0; n < NIB; n++)
                if ($urandom_range(0, 3) == 0) rb[n*4 +: 4] = 4'($urandom);
            run_txn(ra, rb, 3'($urandom), ($urandom_range(0, 3) == 0), cyc);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
